gctr_present64: RTL and testbench



---
 rtl/gctr_present64_if.sv | 41 ++++
 rtl/gctr_present64.sv | 262 ++++++++++++++++++++++++++
 tb/tb_gctr_present64.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gctr_present64_if.sv
// gctr_present64_if: request, data and result signals of the GCTR controller.
// With GCTR_TAG_MASK_EN defined the interface also carries the tag-mask result
// E(K, J0) and its valid flag.
interface gctr_present64_if;
  logic        start;
  logic [63:0] icb_in;
  logic [79:0] key;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef GCTR_TAG_MASK_EN
  logic [63:0] tag_mask;
  logic        tag_mask_valid;
`endif

  // Side that issues messages and consumes results.
  modport master (
    output start, icb_in, key, in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
`ifdef GCTR_TAG_MASK_EN
    , input tag_mask, tag_mask_valid
`endif
  );

  // The GCTR controller itself.
  modport slave (
    input  start, icb_in, key, in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
`ifdef GCTR_TAG_MASK_EN
    , output tag_mask, tag_mask_valid
`endif
  );
endinterface

// File: rtl/gctr_present64.sv
// gctr_present64: counter-mode (GCTR) controller around an iterative PRESENT-80
// core. Each accepted data block encrypts the current counter block, XORs the
// keystream with the data, masks off unused tail bytes of a final partial block
// and offers the result downstream. The low 32 counter bits step (mod 2^32)
// between blocks.
// Optional feature macro: GCTR_TAG_MASK_EN -- when defined, every message first
// computes tag_mask = E(K, J0) and the data blocks start at inc32(J0).

// present80: one PRESENT round per clock. A load captures the block and key;
// rounds 1..31 are applied on the next 31 edges, after which data_o holds the
// ciphertext (final state XOR round key 32) until the following edge.
module present80 (
  input  logic        clk,
  input  logic        load_i,
  input  logic [79:0] key_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic [63:0] state_q, state_d;
  logic [79:0] rkey_q, rkey_d;
  logic [4:0]  round_q, round_d;

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[6'(4 * n) +: 4] = SBOX[x[6'(4 * n) +: 4]];
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[6'((i * 16) % 63)] = x[6'(i)];
    return y;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Next round, or a fresh block and key on load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = p_layer(s_layer(state_q ^ rkey_q[79:16]));
    rkey_d  = key_update(rkey_q, round_q);
    round_d = round_q + 5'd1;
    if (load_i) begin
      state_d = data_i;
      rkey_d  = key_i;
      round_d = 5'd1;
    end
  end

  // Round registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: no reset here -- every use of the core starts with a load.
    state_q <= state_d;
    rkey_q  <= rkey_d;
    round_q <= round_d;
  end

  assign data_o = state_q ^ rkey_q[79:16];
endmodule

module gctr_present64 (
  input  logic             clk,
  input  logic             rst,
  gctr_present64_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_RUN     = 3'd2,
    S_OUT     = 3'd3
`ifdef GCTR_TAG_MASK_EN
    , S_MASK  = 3'd4
`endif
  } state_e;

  state_e      state_q;
  logic [4:0]  run_cnt_q;
  logic [79:0] key_q;
  logic [63:0] ctr_q;
  logic [63:0] data_q;
  logic        last_q;
  logic [3:0]  nbytes_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic        out_last_q;
  logic        busy_q;
  logic        done_q;
`ifdef GCTR_TAG_MASK_EN
  logic [63:0] tag_mask_q;
  logic        tag_mask_valid_q;
`endif

  logic        start_ok;
  logic        accept;
  logic        cipher_load;
  logic [79:0] core_key;
  logic [63:0] core_data;
  logic [63:0] keystream;
  logic [63:0] ctr_inc;
  logic [3:0]  n_keep;
  logic [63:0] keep_mask;

  assign start_ok = bus.start & (state_q == S_IDLE);
  assign accept   = bus.in_valid & in_ready_q;
  assign ctr_inc  = {ctr_q[63:32], ctr_q[31:0] + 32'd1};

  // The key arrives on the bus only during the start cycle; afterwards the latched copy is used.
  assign core_key = start_ok ? bus.key : key_q;
`ifdef GCTR_TAG_MASK_EN
  assign cipher_load = accept | start_ok;
  assign core_data   = start_ok ? bus.icb_in : ctr_q;
`else
  assign cipher_load = accept;
  assign core_data   = ctr_q;
`endif

  present80 u_core (
    .clk    (clk),
    .load_i (cipher_load),
    .key_i  (core_key),
    .data_i (core_data),
    .data_o (keystream)
  );

  // Keep the top N bytes of the result; a final block may be partial, others are always full.
  always_comb begin
    n_keep = 4'd8;
    if (last_q && nbytes_q != 4'd0 && nbytes_q <= 4'd8) n_keep = nbytes_q;
    keep_mask = '0;
    for (int b = 0; b < 8; b++) begin
      keep_mask[6'(63 - 8 * b) -: 8] = (4'(b) < n_keep) ? 8'hFF : 8'h00;
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      run_cnt_q        <= '0;
      in_ready_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_last_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef GCTR_TAG_MASK_EN
      tag_mask_q       <= '0;
      tag_mask_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
`ifdef GCTR_TAG_MASK_EN
            state_q          <= S_MASK;
            run_cnt_q        <= '0;
            tag_mask_valid_q <= 1'b0;
`else
            state_q    <= S_WAIT_IN;
            in_ready_q <= 1'b1;
`endif
          end
        end
`ifdef GCTR_TAG_MASK_EN
        S_MASK: begin
          run_cnt_q <= run_cnt_q + 5'd1;
          if (run_cnt_q == 5'd31) begin
            tag_mask_q       <= keystream;
            tag_mask_valid_q <= 1'b1;
            in_ready_q       <= 1'b1;
            state_q          <= S_WAIT_IN;
          end
        end
`endif
        S_WAIT_IN: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            run_cnt_q  <= '0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          run_cnt_q <= run_cnt_q + 5'd1;
          if (run_cnt_q == 5'd31) begin
            out_data_q  <= (data_q ^ keystream) & keep_mask;
            out_last_q  <= last_q;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_WAIT_IN;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Message datapath: key and counter latched at start, counter stepped between blocks, input block captured on accept.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      key_q <= bus.key;
      ctr_q <= bus.icb_in;
    end
`ifdef GCTR_TAG_MASK_EN
    else if (state_q == S_MASK && run_cnt_q == 5'd31) begin
      ctr_q <= ctr_inc;
    end
`endif
    else if (state_q == S_OUT && bus.out_ready && !out_last_q) begin
      ctr_q <= ctr_inc;
    end
    if (accept) begin
      data_q   <= bus.in_data;
      last_q   <= bus.in_last;
      nbytes_q <= bus.in_nbytes;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef GCTR_TAG_MASK_EN
  assign bus.tag_mask       = tag_mask_q;
  assign bus.tag_mask_valid = tag_mask_valid_q;
`endif
endmodule

// File: tb/tb_gctr_present64.sv
// tb_gctr_present64: directed and randomized messages for gctr_present64,
// checked against an algorithmic PRESENT-80 / GCTR reference model.
// Covers GCTR_TAG_MASK_EN in both settings.
module tb_gctr_present64;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gctr_present64_if bus ();

  gctr_present64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [79:0] ref_key;
  logic [63:0] ref_ctr;
  logic [63:0] got;
  logic [63:0] got2;
  logic [79:0] k;
  logic [63:0] icb;

  localparam logic [3:0] REF_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Textbook PRESENT-80: derive all 32 round keys, then 31 rounds and a final whitening.
  function automatic logic [63:0] ref_present80(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] kr;
    logic [63:0] rk [1:32];
    logic [63:0] s, t, p;
    kr = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r]     = kr[79:16];
      kr        = {kr[18:0], kr[79:19]};
      kr[79:76] = REF_SBOX[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) t[4 * n +: 4] = REF_SBOX[s[4 * n +: 4]];
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      s = p;
    end
    return s ^ rk[32];
  endfunction

  function automatic logic [63:0] keep_mask(input logic last, input logic [3:0] nb);
    int n;
    n = (last && nb >= 4'd1 && nb <= 4'd8) ? int'(nb) : 8;
    return ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * n));
  endfunction

  function automatic logic [63:0] inc32(input logic [63:0] c);
    return {c[63:32], c[31:0] + 32'd1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string pfx);
    check1({pfx, "_in_ready"},  bus.in_ready,  1'b0);
    check1({pfx, "_out_valid"}, bus.out_valid, 1'b0);
    check ({pfx, "_out_data"},  bus.out_data,  64'd0);
    check1({pfx, "_out_last"},  bus.out_last,  1'b0);
    check1({pfx, "_busy"},      bus.busy,      1'b0);
    check1({pfx, "_done"},      bus.done,      1'b0);
`ifdef GCTR_TAG_MASK_EN
    check ({pfx, "_tag_mask"},       bus.tag_mask,       64'd0);
    check1({pfx, "_tag_mask_valid"}, bus.tag_mask_valid, 1'b0);
`endif
  endtask

  task automatic start_msg(input logic [79:0] key, input logic [63:0] j0);
    int w;
    bus.key    = key;
    bus.icb_in = j0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.key    = {16'($urandom()), $urandom(), $urandom()};
    bus.icb_in = {$urandom(), $urandom()};
    ref_key    = key;
    ref_ctr    = j0;
    check1("busy_after_start", bus.busy, 1'b1);
`ifdef GCTR_TAG_MASK_EN
    check1("in_ready_in_mask", bus.in_ready, 1'b0);
    check1("tag_valid_cleared", bus.tag_mask_valid, 1'b0);
    w = 0;
    while (bus.tag_mask_valid !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("tag_mask_latency", 64'(w), 64'd32);
    check("tag_mask", bus.tag_mask, ref_present80(key, j0));
    check1("in_ready_after_mask", bus.in_ready, 1'b1);
    ref_ctr = inc32(j0);
`else
    w = 0;
    check1("in_ready_after_start", bus.in_ready, 1'b1);
`endif
  endtask

  task automatic send_block(input logic [63:0] data, input logic last, input logic [3:0] nbytes,
                            input int stall, input bit poke, output logic [63:0] result);
    logic [63:0] exp;
    int w, lat;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check1("in_ready_before_accept", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.in_nbytes = nbytes;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_data   = {$urandom(), $urandom()};
    bus.in_last   = ~last;
    bus.in_nbytes = 4'($urandom_range(0, 15));
    check1("in_ready_after_accept", bus.in_ready, 1'b0);
    exp = (data ^ ref_present80(ref_key, ref_ctr)) & keep_mask(last, nbytes);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (poke && lat == 5) begin
        bus.start  = 1'b1;
        bus.key    = {16'($urandom()), $urandom(), $urandom()};
        bus.icb_in = {$urandom(), $urandom()};
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("result_latency", 64'(lat), 64'd32);
    check("out_data", bus.out_data, exp);
    check1("out_last", bus.out_last, last);
    for (int i = 0; i < stall; i++) begin
      bus.start = poke && (i == 0);
      tick();
      check ("stall_out_data",  bus.out_data,  exp);
      check1("stall_out_last",  bus.out_last,  last);
      check1("stall_out_valid", bus.out_valid, 1'b1);
      check1("stall_in_ready",  bus.in_ready,  1'b0);
    end
    bus.start     = 1'b0;
    result        = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check1("out_valid_after_hs", bus.out_valid, 1'b0);
    if (last) begin
      check1("done_pulse", bus.done, 1'b1);
      check1("busy_at_done", bus.busy, 1'b0);
      tick();
      check1("done_one_cycle", bus.done, 1'b0);
      check1("busy_idle", bus.busy, 1'b0);
    end else begin
      check1("in_ready_next_block", bus.in_ready, 1'b1);
      check1("no_done_mid_msg", bus.done, 1'b0);
      ref_ctr = inc32(ref_ctr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nblk;
    logic [3:0] nb;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.icb_in    = '0;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Known-answer vector: key 0, J0 0, one zero block.
    start_msg(80'd0, 64'd0);
    send_block(64'd0, 1'b1, 4'd8, 0, 1'b0, got);
`ifdef GCTR_TAG_MASK_EN
    check("tag_mask_kat", bus.tag_mask, 64'h5579C1387B228445);
    check1("tag_valid_holds", bus.tag_mask_valid, 1'b1);
`else
    check("basic_kat", got, 64'h5579C1387B228445);
`endif

    // Counter wrap, backpressure with ignored starts, then a 3-byte final block.
    start_msg(80'hFFFF_FFFFFFFF_FFFFFFFF, 64'h12345678FFFFFFFF);
    send_block({$urandom(), $urandom()}, 1'b0, 4'd3, 10, 1'b1, got);
    send_block({$urandom(), $urandom()}, 1'b1, 4'd3, 0, 1'b0, got2);
    check("partial_tail_zero", {24'd0, got2[39:0]}, 64'd0);

    // Reset in the middle of RUN, then a normal restart.
    start_msg({16'($urandom()), $urandom(), $urandom()}, {$urandom(), $urandom()});
    while (bus.in_ready !== 1'b1) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom(), $urandom()};
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_run_reset");
    start_msg({16'($urandom()), $urandom(), $urandom()}, {$urandom(), $urandom()});
    send_block({$urandom(), $urandom()}, 1'b1, 4'd0, 2, 1'b0, got);

    // Reset and start in the same cycle: reset wins.
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check1("rst_start_busy", bus.busy, 1'b0);
    check1("rst_start_in_ready", bus.in_ready, 1'b0);
    tick();
    check1("rst_start_still_idle", bus.busy, 1'b0);

    // Randomized messages, some with counters close to the 32-bit wrap.
    for (int m = 0; m < 6; m++) begin
      k   = {16'($urandom()), $urandom(), $urandom()};
      icb = {$urandom(), ($urandom_range(0, 1) != 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 2))) : $urandom()};
      nblk = int'($urandom_range(1, 3));
      start_msg(k, icb);
      for (int b = 0; b < nblk; b++) begin
        nb = 4'($urandom_range(0, 8));
        send_block({$urandom(), $urandom()}, (b == nblk - 1), nb,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0), got);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
